// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: controller state encoding and
// the terminal values of each displayed field.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      FULL  = 2'd3
   } state_t;

   localparam logic [7:0] CSEC_MAX = 8'h99;
   localparam logic [7:0] SEC_MAX  = 8'h59;
   localparam logic [7:0] MIN_MAX  = 8'h99;

   // Full live count in display order {min, sec, csec}.
   localparam logic [23:0] COUNT_MAX = {MIN_MAX, SEC_MAX, CSEC_MAX};

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch cascade: counts on enable, wraps to zero
// after its terminal value and flags the wrap so the next digit can advance.
module bcd_digit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [3:0] last,
   output logic [3:0] value,
   output logic [3:0] value_next,
   output logic       carry
);

   logic [3:0] count;

   assign carry = en & (count == last);

   // The next value is exported so the display can load it on the same edge.
   always_comb begin
      value_next = count;
      if (clr) begin
         value_next = 4'd0;
      end else if (carry) begin
         value_next = 4'd0;
      end else if (en) begin
         value_next = count + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 4'd0;
      end else begin
         count <= value_next;
      end
   end

   assign value = count;

endmodule

// File: rtl/stopwatch_bcd.sv
// Stopwatch counting MM:SS.cc in BCD from an asynchronous 100 Hz tick, with
// start/stop/zero control, lap freeze of the display and overflow hold.
module stopwatch_bcd
   import stopwatch_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       ClkIn,
   input  logic       Clr_,
   input  logic       Tick100,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Zero,
   input  logic       Lap,
   output logic [7:0] Csec,
   output logic [7:0] Sec,
   output logic [7:0] Min,
   output logic       Running,
   output logic       Ovf,
   output logic       SecTick
);

   logic [SYNC_STAGES-1:0] sync;
   logic [SYNC_STAGES-1:0] fill;
   logic                   hist;
   logic                   armed;
   logic                   tick_event;

   state_t state;
   state_t state_next;
   logic   clear_count;
   logic   lap_toggle;
   logic   at_max;
   logic   inc;
   logic   freeze;

   logic [3:0]  csec_lo, csec_hi, sec_lo, sec_hi, min_lo, min_hi;
   logic [3:0]  csec_lo_n, csec_hi_n, sec_lo_n, sec_hi_n, min_lo_n, min_hi_n;
   logic        c_csec_lo, c_csec_hi, c_sec_lo, c_sec_hi, c_min_lo;
   logic        c_min_hi_unused;
   logic [23:0] live;
   logic [23:0] live_next;

   // Synchronizer plus edge history. The fill chain marks when the last sync
   // stage holds a real sample; events stay disarmed until that sample has
   // been low once, so a tick already high at reset release is not counted.
   always_ff @(posedge ClkIn or negedge Clr_) begin
      if (!Clr_) begin
         sync  <= '0;
         fill  <= '0;
         hist  <= 1'b0;
         armed <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], Tick100};
         fill <= {fill[SYNC_STAGES-2:0], 1'b1};
         hist <= sync[SYNC_STAGES-1];
         if (fill[SYNC_STAGES-1] && !sync[SYNC_STAGES-1]) begin
            armed <= 1'b1;
         end
      end
   end

   assign tick_event = armed & sync[SYNC_STAGES-1] & ~hist;

   assign live      = {min_hi, min_lo, sec_hi, sec_lo, csec_hi, csec_lo};
   assign live_next = {min_hi_n, min_lo_n, sec_hi_n, sec_lo_n, csec_hi_n, csec_lo_n};
   assign at_max    = (live == COUNT_MAX);
   assign inc       = (state == RUN) & tick_event & ~at_max;
   assign lap_toggle = Lap & ((state == RUN) | (state == PAUSE));

   always_ff @(posedge ClkIn or negedge Clr_) begin
      if (!Clr_) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Stop beats Start, and Zero beats Start, wherever they coincide.
   always_comb begin
      state_next  = state;
      clear_count = 1'b0;
      case (state)
         IDLE: begin
            if (Start && !Stop) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (tick_event && at_max) begin
               state_next = FULL;
            end else if (Stop) begin
               state_next = PAUSE;
            end
         end
         PAUSE: begin
            if (Zero) begin
               state_next  = IDLE;
               clear_count = 1'b1;
            end else if (Start && !Stop) begin
               state_next = RUN;
            end
         end
         FULL: begin
            if (Zero) begin
               state_next  = IDLE;
               clear_count = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status flags are decoded from the next state so they track the state
   // register exactly while still coming straight from flops.
   always_ff @(posedge ClkIn or negedge Clr_) begin
      if (!Clr_) begin
         Running <= 1'b0;
         Ovf     <= 1'b0;
         SecTick <= 1'b0;
      end else begin
         Running <= (state_next == RUN);
         Ovf     <= (state_next == FULL);
         SecTick <= c_csec_hi;
      end
   end

   always_ff @(posedge ClkIn or negedge Clr_) begin
      if (!Clr_) begin
         freeze <= 1'b0;
      end else if (state_next == IDLE) begin
         freeze <= 1'b0;
      end else if (lap_toggle) begin
         freeze <= ~freeze;
      end
   end

   // A clear also refreshes a frozen display so it never shows a stale lap.
   always_ff @(posedge ClkIn or negedge Clr_) begin
      if (!Clr_) begin
         {Min, Sec, Csec} <= '0;
      end else if (!freeze || clear_count) begin
         {Min, Sec, Csec} <= live_next;
      end
   end

   bcd_digit u_csec_lo (
      .clk        (ClkIn),
      .rst_n      (Clr_),
      .clr        (clear_count),
      .en         (inc),
      .last       (CSEC_MAX[3:0]),
      .value      (csec_lo),
      .value_next (csec_lo_n),
      .carry      (c_csec_lo)
   );

   bcd_digit u_csec_hi (
      .clk        (ClkIn),
      .rst_n      (Clr_),
      .clr        (clear_count),
      .en         (c_csec_lo),
      .last       (CSEC_MAX[7:4]),
      .value      (csec_hi),
      .value_next (csec_hi_n),
      .carry      (c_csec_hi)
   );

   bcd_digit u_sec_lo (
      .clk        (ClkIn),
      .rst_n      (Clr_),
      .clr        (clear_count),
      .en         (c_csec_hi),
      .last       (SEC_MAX[3:0]),
      .value      (sec_lo),
      .value_next (sec_lo_n),
      .carry      (c_sec_lo)
   );

   bcd_digit u_sec_hi (
      .clk        (ClkIn),
      .rst_n      (Clr_),
      .clr        (clear_count),
      .en         (c_sec_lo),
      .last       (SEC_MAX[7:4]),
      .value      (sec_hi),
      .value_next (sec_hi_n),
      .carry      (c_sec_hi)
   );

   bcd_digit u_min_lo (
      .clk        (ClkIn),
      .rst_n      (Clr_),
      .clr        (clear_count),
      .en         (c_sec_hi),
      .last       (MIN_MAX[3:0]),
      .value      (min_lo),
      .value_next (min_lo_n),
      .carry      (c_min_lo)
   );

   // Increments stop at 99:59.99, so the top digit never carries out.
   bcd_digit u_min_hi (
      .clk        (ClkIn),
      .rst_n      (Clr_),
      .clr        (clear_count),
      .en         (c_min_lo),
      .last       (MIN_MAX[7:4]),
      .value      (min_hi),
      .value_next (min_hi_n),
      .carry      (c_min_hi_unused)
   );

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on Tick100; legal values 2..3.
REQ-002 ClkIn  input  1  50 MHz system clock; all state changes on rising edge.
REQ-003 Clr_  input  1  asynchronous active-low reset.
REQ-004 Tick100  input  1  100 Hz pulse from the clock-divider stage, asynchronous to ClkIn.
REQ-005 Start  input  1  one-ClkIn-cycle command pulse: begin or resume counting.
REQ-006 Stop  input  1  one-ClkIn-cycle command pulse: pause counting.
REQ-007 Zero  input  1  one-ClkIn-cycle command pulse: clear count.
REQ-008 Lap  input  1  one-ClkIn-cycle command pulse: toggle display freeze.
REQ-009 Csec  output  8  displayed hundredths, two BCD digits [7:4] tens, [3:0] units.
REQ-010 Sec  output  8  displayed seconds, two BCD digits, 00..59.
REQ-011 Min  output  8  displayed minutes, two BCD digits, 00..99.
REQ-012 Running  output  1  high while state is RUN.
REQ-013 Ovf  output  1  high while state is FULL.
REQ-014 SecTick  output  1  one-cycle pulse on each live seconds increment.

Function
REQ-015 Tick100 shall pass through SYNC_STAGES flops plus one history flop; tick event = last sync stage high AND history flop low.
REQ-016 Live count shall increment on the ClkIn edge at which a tick event is true; latency from first ClkIn edge sampling Tick100 high to updated count = SYNC_STAGES+1 edges.
REQ-017 One Tick100 high period of any length shall yield exactly one increment.
REQ-018 FSM states: IDLE, RUN, PAUSE, FULL; count advances only in RUN.
REQ-019 IDLE: Start -> RUN; Stop, Zero, Lap ignored.
REQ-020 RUN: Stop -> PAUSE; Zero ignored; tick event with live count 99:59.99 -> FULL, count held at 99:59.99.
REQ-021 PAUSE: Start -> RUN; Zero -> IDLE with live count 00:00.00.
REQ-022 FULL: Zero -> IDLE with live count cleared; Start and Stop ignored.
REQ-023 Start and Stop in the same cycle: Stop wins.
REQ-024 Start and Zero in the same cycle in PAUSE: Zero wins.
REQ-025 Tick event coincident with Stop in RUN: increment applied; state becomes PAUSE.
REQ-026 Cascade: Csec units 9 -> 0 carries to tens; Csec 99 -> 00 carries to Sec; Sec 59 -> 00 carries to Min; SecTick asserted in the cycle after the Sec increment edge.
REQ-027 Display registers shall copy the live count every cycle unless frozen.
REQ-028 Lap in RUN or PAUSE toggles freeze; leaving freeze resumes copying on the next edge.
REQ-029 Freeze shall clear on entering IDLE.
REQ-030 Freeze is unaffected by entering FULL.
REQ-031 Running and Ovf are registered decodes of state.

Reset
REQ-032 Clr_ low shall immediately force state IDLE; live and display counts 00:00.00; freeze 0; Running, Ovf, SecTick 0; all sync flops 0.
REQ-033 Reset mid-count shall discard the count; a Tick100 high at release shall not create an event until it has gone low then high.

Structure
REQ-034 Shared package stopwatch_pkg shall hold the state encoding and BCD limit constants (CSEC_MAX 8'h99, SEC_MAX 8'h59, MIN_MAX 8'h99).
REQ-035 Sub-module bcd_digit: one 4-bit BCD digit with enable, programmable terminal value, carry-out, clear; instantiated six times.

Verification
REQ-036 Start, then 150 Tick100 pulses, then Stop -> Csec=8'h50, Sec=8'h01, Min=8'h00, one SecTick pulse, Running=0.
REQ-037 Preload to 99:59.98 via ticks, one more tick -> 99:59.99; next tick -> Ovf=1, count holds; Zero -> 00:00.00, Ovf=0.
REQ-038 Lap at count 00:02.00, then 300 ticks -> outputs stay 00:02.00; second Lap -> outputs 00:05.00 next cycle.
REQ-039 Start and Stop in the same cycle from PAUSE -> remain PAUSE; Start with Zero -> IDLE with count zero.
REQ-040 Tick100 held high 10,000 ClkIn cycles -> exactly one increment, appearing SYNC_STAGES+1 edges after first high sample.
REQ-041 Clr_ pulsed low at 00:07.42 while RUN -> all outputs 0 immediately; Running=0 after release.
